// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache: 8 lines x 4 words, 0-cycle hits,
// whole-block refill from instruction memory on a miss.
module instruction_cache (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [9:0]   PC,
  output logic [31:0]  INSTRUCTION,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic [5:0]   MEM_ADDRESS,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MEM_READ = 2'd1;
  localparam logic [1:0] ST_UPDATE   = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [7:0]   valid_q, valid_d;
  logic [2:0]   tag_q [8];
  logic [127:0] data_q [8];
  logic [2:0]   req_tag_q, req_tag_d;
  logic [2:0]   req_index_q, req_index_d;
  logic [31:0]  instr_q, instr_d;

  logic [1:0]   pc_offset;
  logic [2:0]   pc_index;
  logic [2:0]   pc_tag;
  logic         hit;
  logic         fill_en;
  logic [127:0] line_data;
  logic [31:0]  line_word;
  logic         unused_pc_bits;

  assign pc_offset      = PC[3:2];
  assign pc_index       = PC[6:4];
  assign pc_tag         = PC[9:7];
  assign unused_pc_bits = ^PC[1:0];

  assign line_data = data_q[pc_index];
  assign hit       = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);

  always_comb begin
    line_word = line_data[31:0];
    case (pc_offset)
      2'd0:    line_word = line_data[31:0];
      2'd1:    line_word = line_data[63:32];
      2'd2:    line_word = line_data[95:64];
      default: line_word = line_data[127:96];
    endcase
  end

  // The fill target is captured at miss detection so a wandering PC cannot redirect it.
  always_comb begin
    state_d     = state_q;
    req_tag_d   = req_tag_q;
    req_index_d = req_index_q;
    instr_d     = instr_q;
    fill_en     = 1'b0;
    MEM_READ    = 1'b0;
    BUSYWAIT    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          instr_d = line_word;
        end else begin
          BUSYWAIT    = 1'b1;
          req_tag_d   = pc_tag;
          req_index_d = pc_index;
          state_d     = ST_MEM_READ;
        end
      end
      ST_MEM_READ: begin
        MEM_READ = 1'b1;
        BUSYWAIT = 1'b1;
        if (!MEM_BUSYWAIT) begin
          fill_en = 1'b1;
          state_d = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        BUSYWAIT = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        BUSYWAIT = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase
    if (RESET) begin
      state_d  = ST_IDLE;
      fill_en  = 1'b0;
      BUSYWAIT = 1'b0;
    end
    MEM_ADDRESS = MEM_READ ? {req_tag_q, req_index_q} : 6'd0;
  end

  always_comb begin
    valid_d = valid_q;
    if (fill_en) begin
      valid_d[req_index_q] = 1'b1;
    end
  end

  assign INSTRUCTION = instr_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      valid_q     <= 8'd0;
      req_tag_q   <= 3'd0;
      req_index_q <= 3'd0;
      instr_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      req_tag_q   <= req_tag_d;
      req_index_q <= req_index_d;
      instr_q     <= instr_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone decide hits.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[req_index_q]  <= req_tag_q;
      data_q[req_index_q] <= MEM_READDATA;
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed self-checking bench for instruction_cache with a small
// latency-programmable instruction memory responder.
module tb_instruction_cache;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [9:0]   PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int checks    = 0;
  int failures  = 0;
  int mem_lat   = 0;
  int mem_cnt   = 0;
  int mem_reads = 0;

  instruction_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  // Word k of block a holds (a << 8) + k + 1, so block 0 is 1,2,3,4.
  function automatic logic [127:0] mem_block(input logic [5:0] a);
    logic [127:0] b;
    b = '0;
    for (int k = 0; k < 4; k++) begin
      b[32*k +: 32] = (32'(a) << 8) + 32'(k) + 32'd1;
    end
    return b;
  endfunction

  assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < mem_lat);
  assign MEM_READDATA = MEM_BUSYWAIT ? {4{32'hDEADBEEF}} : mem_block(MEM_ADDRESS);

  always @(posedge CLK) begin
    if (MEM_READ) begin
      if (mem_cnt == 0) mem_reads <= mem_reads + 1;
      mem_cnt <= mem_cnt + 1;
    end else begin
      mem_cnt <= 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] pc);
    @(negedge CLK);
    PC = pc;
    #1;
  endtask

  // Called in the miss cycle; runs until BUSYWAIT drops or the cycle budget expires.
  task automatic waitFill(input string name, input int lat, input logic [5:0] exp_addr,
                          input logic [31:0] exp_instr);
    int n;
    int rd;
    int bad;
    n = 0;
    rd = 0;
    bad = 0;
    mem_lat = lat;
    do begin
      @(negedge CLK);
      #1;
      n++;
      if (MEM_READ === 1'b1) begin
        rd++;
        if (MEM_ADDRESS !== exp_addr) bad++;
      end
    end while (BUSYWAIT !== 1'b0 && n < 60);
    checkOutput({name, " busy cycles"}, 32'(n - 1), 32'(lat + 2));
    checkOutput({name, " mem_read cycles"}, 32'(rd), 32'(lat + 1));
    checkOutput({name, " bad mem_address"}, 32'(bad), 32'd0);
    checkOutput({name, " instruction"}, INSTRUCTION, exp_instr);
  endtask

  task automatic missAndFill(input string name, input logic [9:0] pc, input int lat,
                             input logic [5:0] exp_addr, input logic [31:0] exp_instr);
    mem_lat = lat;
    applyStimulus(pc);
    checkOutput({name, " miss busywait"}, 32'(BUSYWAIT), 32'd1);
    checkOutput({name, " miss mem_read"}, 32'(MEM_READ), 32'd0);
    waitFill(name, lat, exp_addr, exp_instr);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic [5:0] a;
    int reads_before;

    RESET = 1'b1;
    PC = 10'h000;
    repeat (2) @(negedge CLK);
    #1;
    checkOutput("reset busywait", 32'(BUSYWAIT), 32'd0);
    checkOutput("reset mem_read", 32'(MEM_READ), 32'd0);
    checkOutput("reset mem_address", 32'(MEM_ADDRESS), 32'd0);

    // Cold miss, memory busy for 5 cycles
    mem_lat = 5;
    @(negedge CLK);
    RESET = 1'b0;
    PC = 10'h000;
    #1;
    checkOutput("cold miss busywait", 32'(BUSYWAIT), 32'd1);
    waitFill("cold miss", 5, 6'b000000, 32'h00000001);

    // Hits on the remaining words of the freshly filled line
    applyStimulus(10'h004);
    checkOutput("hit 004 busywait", 32'(BUSYWAIT), 32'd0);
    checkOutput("hit 004 instruction", INSTRUCTION, 32'h00000002);
    checkOutput("hit 004 mem_read", 32'(MEM_READ), 32'd0);
    applyStimulus(10'h008);
    checkOutput("hit 008 busywait", 32'(BUSYWAIT), 32'd0);
    checkOutput("hit 008 instruction", INSTRUCTION, 32'h00000003);
    checkOutput("hit 008 mem_read", 32'(MEM_READ), 32'd0);
    applyStimulus(10'h00C);
    checkOutput("hit 00C busywait", 32'(BUSYWAIT), 32'd0);
    checkOutput("hit 00C instruction", INSTRUCTION, 32'h00000004);
    checkOutput("hit 00C mem_read", 32'(MEM_READ), 32'd0);

    // Conflict on index 0, then the evicted line must miss again
    missAndFill("conflict 080", 10'h080, 3, 6'b001000, 32'h00000801);
    missAndFill("refetch 000", 10'h000, 2, 6'b000000, 32'h00000001);

    // Reset while the fill of index 1 is waiting on memory
    mem_lat = 5;
    applyStimulus(10'h010);
    checkOutput("abort miss busywait", 32'(BUSYWAIT), 32'd1);
    @(negedge CLK);
    #1;
    checkOutput("abort in mem_read", 32'(MEM_READ), 32'd1);
    checkOutput("abort mem_address", 32'(MEM_ADDRESS), 32'h01);
    RESET = 1'b1;
    @(negedge CLK);
    #1;
    checkOutput("abort mem_read dropped", 32'(MEM_READ), 32'd0);
    checkOutput("abort mem_address zero", 32'(MEM_ADDRESS), 32'd0);
    checkOutput("abort busywait in reset", 32'(BUSYWAIT), 32'd0);
    RESET = 1'b0;
    #1;
    checkOutput("after abort miss", 32'(BUSYWAIT), 32'd1);
    waitFill("refill 010", 5, 6'b000001, 32'h00000101);

    // Index 0 was invalidated by reset; memory answers on the first read cycle
    missAndFill("min latency", 10'h000, 0, 6'b000000, 32'h00000001);

    // Fill all eight indexes with tag 2, then reread every word
    for (int i = 0; i < 8; i++) begin
      a = {3'd2, 3'(i)};
      missAndFill("sweep fill", {a, 4'b0000}, 1, a, (32'(a) << 8) + 32'd1);
    end
    reads_before = mem_reads;
    for (int i = 0; i < 8; i++) begin
      a = {3'd2, 3'(i)};
      for (int k = 0; k < 4; k++) begin
        applyStimulus({a, 2'(k), 2'b00});
        checkOutput("sweep reread busywait", 32'(BUSYWAIT), 32'd0);
        checkOutput("sweep reread instruction", INSTRUCTION, (32'(a) << 8) + 32'(k) + 32'd1);
      end
    end
    checkOutput("sweep memory reads", 32'(mem_reads - reads_before), 32'd0);

    // Low PC bits are ignored: 0x10F selects word 3 of block {2,0}
    applyStimulus(10'h10F);
    checkOutput("byte bits ignored busywait", 32'(BUSYWAIT), 32'd0);
    checkOutput("byte bits ignored instruction", INSTRUCTION, 32'h00001004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
